// File: rtl/serial_increment_pkg.sv
// Shared definitions for the bit-serial incrementer:
// FSM state encodings, default width and counter sizing.
package serial_increment_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Step counter width, never narrower than one bit.
  function automatic int cnt_w(input int w);
    return (w > 2) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/serial_increment_increment_bit.sv
// One-bit increment cell: sum and carry-out of bit plus carry-in.
// Up-direction mirror of the 1-bit decrement cell.
module increment_bit (
  input  logic A,
  input  logic cin,
  output logic out,
  output logic cout
);

  assign out  = A ^ cin;
  assign cout = A & cin;

endmodule

// File: rtl/serial_increment.sv
// Bit-serial a+1 using a single increment cell and a carry register.
// One bit per RUN cycle; start/busy/done handshake, registered result.
module serial_increment
  import serial_increment_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout
);

  localparam int CW = cnt_w(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] opnd_q;
  logic [WIDTH-1:0] work_q;
  logic [WIDTH-1:0] res_q;
  logic             carry_q;
  logic             cout_q;
  logic [CW-1:0]    cnt_q;

  logic accept;
  logic last;
  logic sum;
  logic c;

  increment_bit u_cell (
    .A   (opnd_q[0]),
    .cin (carry_q),
    .out (sum),
    .cout(c)
  );

  assign accept = start &&
    (state_q == S_IDLE || state_q == S_DONE);
  assign last = (state_q == S_RUN) &&
    (cnt_q == CW'(WIDTH - 1));

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (last)  state_d = S_DONE;
      S_DONE:  state_d = start ? S_RUN : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Status outputs decoded from the state register
  always_comb begin
    busy = (state_q == S_RUN);
    done = (state_q == S_DONE);
  end

  // Operand/working shift registers, carry and step counter
  always_ff @(posedge clk) begin
    if (reset) begin
      opnd_q  <= '0;
      work_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else if (accept) begin
      opnd_q  <= a;
      work_q  <= '0;
      carry_q <= 1'b1;
      cnt_q   <= '0;
    end else if (state_q == S_RUN) begin
      opnd_q  <= {1'b0, opnd_q[WIDTH-1:1]};
      work_q  <= {sum, work_q[WIDTH-1:1]};
      carry_q <= c;
      cnt_q   <= cnt_q + CW'(1);
    end
  end

  // Capture the finished value on the final bit step
  always_ff @(posedge clk) begin
    if (reset) begin
      res_q  <= '0;
      cout_q <= 1'b0;
    end else if (last) begin
      res_q  <= {sum, work_q[WIDTH-1:1]};
      cout_q <= c;
    end
  end

  assign result = res_q;
  assign cout   = cout_q;

endmodule

// File: tb/tb_serial_increment.sv
// Self-checking bench for serial_increment (WIDTH 8 and WIDTH 2).
// Countdown reference model plus directed literal checks.
module tb_serial_increment;

  logic       clk = 1'b0;
  logic       reset;
  logic       start8, start2;
  logic [7:0] a8;
  logic [1:0] a2;
  logic       busy8, done8, cout8;
  logic       busy2, done2, cout2;
  logic [7:0] result8;
  logic [1:0] result2;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  always #5 clk = ~clk;

  serial_increment #(.WIDTH(8)) u_dut8 (
    .clk   (clk),
    .reset (reset),
    .start (start8),
    .a     (a8),
    .busy  (busy8),
    .done  (done8),
    .result(result8),
    .cout  (cout8)
  );

  serial_increment #(.WIDTH(2)) u_dut2 (
    .clk   (clk),
    .reset (reset),
    .start (start2),
    .a     (a2),
    .busy  (busy2),
    .done  (done2),
    .result(result2),
    .cout  (cout2)
  );

  typedef struct {
    int          left;
    bit          dn;
    logic [31:0] res;
    bit          co;
    logic [31:0] pr;
    bit          pc;
  } model_t;

  model_t m8, m2;

  initial begin
    m8 = '{0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0};
    m2 = '{0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0};
  end

  function automatic model_t step(input model_t m, input bit rst,
                                  input bit st, input logic [31:0] av,
                                  input int w);
    model_t      n;
    logic [31:0] mask;
    mask = (32'd1 << w) - 32'd1;
    n = m;
    if (rst) begin
      n = '{0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0};
    end else begin
      n.dn = 1'b0;
      if (m.left > 0) begin
        n.left = m.left - 1;
        if (n.left == 0) begin
          n.res = m.pr;
          n.co  = m.pc;
          n.dn  = 1'b1;
        end
      end else if (st) begin
        n.left = w;
        n.pr   = (av + 32'd1) & mask;
        n.pc   = ((av & mask) == mask);
      end
    end
    return n;
  endfunction

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(posedge clk) begin
    m8 = step(m8, reset, start8, {24'd0, a8}, 8);
    m2 = step(m2, reset, start2, {30'd0, a2}, 2);
    if (reset) chk_en = 1'b1;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy8", {31'd0, busy8}, {31'd0, m8.left > 0});
      check("done8", {31'd0, done8}, {31'd0, m8.dn});
      check("result8", {24'd0, result8}, {24'd0, m8.res[7:0]});
      check("cout8", {31'd0, cout8}, {31'd0, m8.co});
      check("busy2", {31'd0, busy2}, {31'd0, m2.left > 0});
      check("done2", {31'd0, done2}, {31'd0, m2.dn});
      check("result2", {30'd0, result2}, {30'd0, m2.res[1:0]});
      check("cout2", {31'd0, cout2}, {31'd0, m2.co});
    end
  end

  task automatic pulse_start(input int w, input logic [7:0] av);
    @(posedge clk); #1;
    if (w == 8) begin start8 = 1'b1; a8 = av; end
    else begin start2 = 1'b1; a2 = av[1:0]; end
    @(posedge clk); #1;
    start8 = 1'b0;
    start2 = 1'b0;
  endtask

  // Returns at the falling edge inside the done cycle.
  task automatic wait_done(input int w, input logic [7:0] er,
                           input bit eco, input bit chklat,
                           input string nm);
    int n  = 0;
    int nb = 0;
    bit got = 1'b0;
    while (!got && n < 3 * w + 10) begin
      @(negedge clk);
      n++;
      if (w == 8) begin
        if (busy8) nb++;
        got = done8;
      end else begin
        if (busy2) nb++;
        got = done2;
      end
    end
    check({nm, "_done_seen"}, {31'd0, got}, 32'd1);
    if (got) begin
      if (chklat) begin
        check({nm, "_latency"}, n - 1, w);
        check({nm, "_busy_cycles"}, nb, w);
      end
      if (w == 8) begin
        check({nm, "_result"}, {24'd0, result8}, {24'd0, er});
        check({nm, "_cout"}, {31'd0, cout8}, {31'd0, eco});
      end else begin
        check({nm, "_result"}, {30'd0, result2}, {30'd0, er[1:0]});
        check({nm, "_cout"}, {31'd0, cout2}, {31'd0, eco});
      end
    end
  endtask

  task automatic expect_no_done8(input int cyc, input string nm);
    int cnt = 0;
    repeat (cyc) begin
      @(negedge clk);
      if (done8) cnt++;
    end
    check(nm, cnt, 0);
  endtask

  initial begin
    reset  = 1'b1;
    start8 = 1'b0;
    start2 = 1'b0;
    a8     = 8'd0;
    a2     = 2'd0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    @(negedge clk);
    check("rst_busy", {31'd0, busy8}, 32'd0);
    check("rst_done", {31'd0, done8}, 32'd0);
    check("rst_result", {24'd0, result8}, 32'd0);
    check("rst_cout", {31'd0, cout8}, 32'd0);

    pulse_start(8, 8'h00);
    wait_done(8, 8'h01, 1'b0, 1'b1, "inc00");
    pulse_start(8, 8'h7F);
    wait_done(8, 8'h80, 1'b0, 1'b1, "inc7F");
    pulse_start(8, 8'hFF);
    wait_done(8, 8'h00, 1'b1, 1'b1, "incFF");

    pulse_start(8, 8'h10);
    @(posedge clk); #1;
    start8 = 1'b1;
    a8     = 8'h55;
    @(posedge clk); #1;
    start8 = 1'b0;
    wait_done(8, 8'h11, 1'b0, 1'b0, "busy_ign");
    expect_no_done8(12, "busy_ign_single");

    pulse_start(8, 8'h0F);
    wait_done(8, 8'h10, 1'b0, 1'b1, "b2b_first");
    start8 = 1'b1;
    a8     = 8'hFE;
    @(posedge clk); #1;
    start8 = 1'b0;
    @(negedge clk);
    check("b2b_no_gap", {31'd0, busy8}, 32'd1);
    wait_done(8, 8'hFF, 1'b0, 1'b0, "b2b_second");

    pulse_start(8, 8'h3C);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("midrst_busy", {31'd0, busy8}, 32'd0);
    check("midrst_done", {31'd0, done8}, 32'd0);
    check("midrst_result", {24'd0, result8}, 32'd0);
    check("midrst_cout", {31'd0, cout8}, 32'd0);
    expect_no_done8(20, "midrst_no_done");
    pulse_start(8, 8'h3C);
    wait_done(8, 8'h3D, 1'b0, 1'b1, "after_rst");

    for (int i = 0; i < 4; i++) begin
      pulse_start(2, 8'(i));
      wait_done(2, 8'((i + 1) % 4), i == 3, 1'b1, "w2");
    end

    repeat (600) begin
      @(posedge clk); #1;
      reset  = ($urandom_range(0, 59) == 0);
      start8 = ($urandom_range(0, 2) == 0);
      start2 = ($urandom_range(0, 2) == 0);
      a8     = 8'($urandom);
      a2     = 2'($urandom);
    end
    @(posedge clk); #1;
    reset  = 1'b0;
    start8 = 1'b0;
    start2 = 1'b0;
    repeat (15) @(posedge clk);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
